// File: rtl/reset_seq_pkg.sv
// Shared state encodings and defaults for the staged reset sequencer.
package reset_seq_pkg;

  localparam logic [2:0] DELAY      = 3'd0;
  localparam logic [2:0] WAIT_READY = 3'd1;
  localparam logic [2:0] DONE       = 3'd2;
  localparam logic [2:0] ERROR      = 3'd3;
  localparam logic [2:0] SWHOLD     = 3'd4;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_CNT_W       = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Control/status bundle between the sequencer and the reset domains.
interface reset_seq_if #(
  parameter int N = 4
);

  logic         sw_reset_req;
  logic [N-1:0] stage_ready;
  logic [N-1:0] stage_reset_n;
  logic         seq_done;
  logic         seq_error;

  modport master (
    input  sw_reset_req,
    input  stage_ready,
    output stage_reset_n,
    output seq_done,
    output seq_error
  );

  modport slave (
    output sw_reset_req,
    output stage_ready,
    input  stage_reset_n,
    input  seq_done,
    input  seq_error
  );

endinterface

// File: rtl/reset_seq_counter.sv
// Up-counter with clear/enable and terminal compare, reused by the
// delay, timeout and software-hold phases.
module reset_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: releases each domain after a delay,
// waits for its ready, flags timeouts, supports software re-sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       sync_reset_n,
  reset_seq_if.master bus
);

  localparam int IW = idx_w(NUM_STAGES);
  localparam logic [IW-1:0]    LAST  = IW'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] DLY_T = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_T  = CNT_W'(TIMEOUT - 1);

  logic [2:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_rel;
  logic                  r_done;
  logic                  r_err;

  logic                  w_hit;
  logic                  w_clr;
  logic                  w_en;
  logic                  w_rdy;
  logic [CNT_W-1:0]      w_term;
  logic [NUM_STAGES-1:0] w_bit;

  assign w_rdy  = bus.stage_ready[r_idx];
  assign w_bit  = NUM_STAGES'(1) << r_idx;
  assign w_term = (r_state == WAIT_READY) ? TO_T : DLY_T;

  // Counter restarts on every phase change; frozen in DONE/ERROR.
  always_comb begin
    w_clr = 1'b0;
    w_en  = 1'b0;
    if (bus.sw_reset_req) begin
      w_clr = 1'b1;
    end else begin
      unique case (r_state)
        DELAY, SWHOLD: begin
          w_clr = w_hit;
          w_en  = !w_hit;
        end
        WAIT_READY: begin
          w_clr = w_rdy | w_hit;
          w_en  = !(w_rdy | w_hit);
        end
        default: ;
      endcase
    end
  end

  reset_seq_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (sync_reset_n),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_term (w_term),
    .o_hit  (w_hit)
  );

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      r_state <= DELAY;
      r_idx   <= '0;
      r_rel   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.sw_reset_req) begin
      r_state <= SWHOLD;
      r_idx   <= '0;
      r_rel   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        DELAY: begin
          if (w_hit) begin
            r_rel   <= r_rel | w_bit;
            r_state <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          // Ready on the timeout cycle still counts as an acknowledge.
          if (w_rdy) begin
            if (r_idx == LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= DELAY;
            end
          end else if (w_hit) begin
            r_state <= ERROR;
            r_err   <= 1'b1;
          end
        end
        SWHOLD: begin
          if (w_hit) begin
            r_idx   <= '0;
            r_state <= DELAY;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stage_reset_n = r_rel;
  assign bus.seq_done      = r_done;
  assign bus.seq_error     = r_err;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: timed expectations queued by
// stimulus, compared by a separate monitor on the falling edge.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int SD = 4;
  localparam int TO = 10;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic sync_reset_n = 1'b0;

  reset_seq_if #(.N(N)) bus ();

  reset_sequencer #(
    .NUM_STAGES  (N),
    .STAGE_DELAY (SD),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           asy;
    logic [N-1:0] rst;
    logic         done;
    logic         err;
    string        tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [N-1:0] rdy_mask = '0;
  logic [N-1:0] rdy_force = '0;
  event ev_async;

  always_comb bus.stage_ready = (bus.stage_reset_n & rdy_mask) | rdy_force;

  always @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic cmp(input exp_t e);
    checks++;
    if (bus.stage_reset_n !== e.rst || bus.seq_done !== e.done ||
        bus.seq_error !== e.err) begin
      errors++;
      $display("FAIL %s cyc %0d: got rst_n=%b done=%b err=%b want rst_n=%b done=%b err=%b",
               e.tag, e.cyc, bus.stage_reset_n, bus.seq_done, bus.seq_error,
               e.rst, e.done, e.err);
    end
  endtask

  // Monitor: async entries are checked on the async event (clk high),
  // timed entries on the falling edge of their cycle.
  initial begin
    forever begin
      @(negedge clk or ev_async);
      if (clk === 1'b1) begin
        if (q.size() > 0 && q[0].asy) begin
          cmp(q[0]);
          void'(q.pop_front());
        end
      end else begin
        while (q.size() > 0 && !q[0].asy && q[0].cyc <= cyc) begin
          if (q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed cyc %0d now %0d", q[0].tag, q[0].cyc, cyc);
          end else begin
            cmp(q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic push(input int c, input logic [N-1:0] r, input logic d,
                      input logic e, input string t);
    exp_t x;
    x.cyc = c; x.asy = 1'b0; x.rst = r; x.done = d; x.err = e; x.tag = t;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 200) begin
      step();
      n++;
    end
    if (cyc < c) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc %0d reached %0d", c, cyc);
    end
  endtask

  task automatic drain(input string t);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors += q.size();
      $display("FAIL drain %s pending %0d", t, q.size());
      q.delete();
    end
  endtask

  task automatic start(input logic [N-1:0] m, input logic [N-1:0] f);
    sync_reset_n     = 1'b0;
    bus.sw_reset_req = 1'b0;
    rdy_mask         = m;
    rdy_force        = f;
    push(0, 3'b000, 1'b0, 1'b0, "reset_state");
    step();
    step();
    step();
  endtask

  task automatic release_rst();
    sync_reset_n = 1'b1;
  endtask

  task automatic sw_pulse();
    bus.sw_reset_req = 1'b1;
    step();
    bus.sw_reset_req = 1'b0;
  endtask

  // Nominal ready-immediately sequence; b offsets the first release.
  task automatic nominal(input int b, input string t);
    push(b + 3,  3'b000, 1'b0, 1'b0, {t, "_pre0"});
    push(b + 4,  3'b001, 1'b0, 1'b0, {t, "_rel0"});
    push(b + 8,  3'b001, 1'b0, 1'b0, {t, "_pre1"});
    push(b + 9,  3'b011, 1'b0, 1'b0, {t, "_rel1"});
    push(b + 13, 3'b011, 1'b0, 1'b0, {t, "_pre2"});
    push(b + 14, 3'b111, 1'b0, 1'b0, {t, "_rel2"});
    push(b + 15, 3'b111, 1'b1, 1'b0, {t, "_done"});
  endtask

  initial begin
    bus.sw_reset_req = 1'b0;

    start(3'b111, 3'b000);
    nominal(0, "nom");
    push(20, 3'b111, 1'b1, 1'b0, "nom_hold");
    release_rst();
    wait_cyc(20);
    sw_pulse();
    push(21, 3'b000, 1'b0, 1'b0, "sw_clear");
    push(25, 3'b000, 1'b0, 1'b0, "sw_hold");
    nominal(25, "resq");
    drain("nominal_sw");

    start(3'b101, 3'b000);
    push(4,  3'b001, 1'b0, 1'b0, "to_rel0");
    push(9,  3'b011, 1'b0, 1'b0, "to_rel1");
    push(18, 3'b011, 1'b0, 1'b0, "to_pre");
    push(19, 3'b011, 1'b0, 1'b1, "to_err");
    push(25, 3'b011, 1'b0, 1'b1, "to_sticky");
    push(27, 3'b000, 1'b0, 1'b0, "to_swclr");
    push(34, 3'b000, 1'b0, 1'b0, "to_swpre");
    push(35, 3'b001, 1'b0, 1'b0, "to_swrel");
    release_rst();
    wait_cyc(26);
    sw_pulse();
    drain("timeout");

    start(3'b101, 3'b000);
    push(18, 3'b011, 1'b0, 1'b0, "edge_pre");
    push(19, 3'b011, 1'b0, 1'b0, "edge_noerr");
    push(22, 3'b011, 1'b0, 1'b0, "edge_pre2");
    push(23, 3'b111, 1'b0, 1'b0, "edge_rel2");
    push(24, 3'b111, 1'b1, 1'b0, "edge_done");
    release_rst();
    wait_cyc(18);
    rdy_force = 3'b010;
    drain("timeout_edge");

    start(3'b111, 3'b000);
    push(4,  3'b001, 1'b0, 1'b0, "ar_rel0");
    push(9,  3'b011, 1'b0, 1'b0, "ar_rel1");
    push(10, 3'b011, 1'b0, 1'b0, "ar_pre");
    release_rst();
    wait_cyc(11);
    begin
      exp_t x;
      x.cyc = -1; x.asy = 1'b1; x.rst = 3'b000;
      x.done = 1'b0; x.err = 1'b0; x.tag = "async_rst";
      q.push_back(x);
    end
    sync_reset_n = 1'b0;
    #1;
    ->ev_async;
    drain("async");
    start(3'b111, 3'b000);
    nominal(0, "restart");
    release_rst();
    drain("restart");

    start(3'b011, 3'b100);
    nominal(0, "rdy2hi");
    push(20, 3'b111, 1'b1, 1'b0, "rdy2hi_hold");
    release_rst();
    drain("rdy2hi");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
